// File: rtl/spike_aer_encoder.sv
// Expands parallel post-neuron spike vectors into per-neuron AER words, queues them with
// time-step markers in a FIFO and drains the FIFO over a 4-phase REQ/ACK output link.
module spike_aer_encoder #(
    parameter int unsigned POST_NEUR_PARALLEL   = 4,
    parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
    parameter int unsigned AER_WIDTH            = 12,
    parameter int unsigned TIME_STEP            = 8,
    parameter int unsigned FIFO_DEPTH           = 16
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              SPIKE_VALID,
    input  logic [POST_NEUR_PARALLEL-1:0]     SPIKE_VEC,
    input  logic [POST_NEUR_ADDR_WIDTH-1:0]   SPIKE_GROUP_ADDR,
    input  logic                              TSTEP_MARK,
    input  logic [$clog2(TIME_STEP)-1:0]      CURRENT_TIME_STEP,
    input  logic                              CLR_OVERFLOW,
    output logic                              SPIKE_READY,
    output logic                              AEROUT_REQ,
    output logic [AER_WIDTH-1:0]              AEROUT_ADDR,
    input  logic                              AEROUT_ACK,
    output logic [$clog2(FIFO_DEPTH):0]       FIFO_COUNT,
    output logic                              OVERFLOW
);

    localparam int unsigned IdxW = $clog2(POST_NEUR_PARALLEL);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TsW  = $clog2(TIME_STEP);
    localparam int unsigned AdrW = POST_NEUR_ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StReq, StAckLow} tx_state_e;

    logic [POST_NEUR_PARALLEL-1:0] pend_q, pend_d;
    logic [AdrW-1:0]               base_q, base_d;
    logic                          marker_q, marker_d;
    logic [TsW-1:0]                ts_q, ts_d;
    logic                          overflow_q, overflow_d;
    logic                          ack_meta_q, ack_sync_q;
    tx_state_e                     state_q, state_d;
    logic [AER_WIDTH-1:0]          addr_q, addr_d;
    logic [AER_WIDTH-1:0]          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]               count_q, count_d;

    logic                 ready, fifo_full, fifo_empty;
    logic                 push, push_spike, push_marker, pop, drop;
    logic [IdxW-1:0]      low_idx;
    logic [AER_WIDTH-1:0] push_word;

    // Input capture and lowest-bit-first expansion of the pending vector.
    always_comb begin
        ready       = (pend_q == '0) && !marker_q;
        fifo_full   = (count_q == CntW'(FIFO_DEPTH));
        fifo_empty  = (count_q == '0);
        push_spike  = (pend_q != '0) && !fifo_full;
        push_marker = (pend_q == '0) && marker_q && !fifo_full;
        push        = push_spike || push_marker;
        drop        = (SPIKE_VALID || TSTEP_MARK) && !ready;

        low_idx = '0;
        for (int i = int'(POST_NEUR_PARALLEL) - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = IdxW'(i);
        end

        push_word = '0;
        if (push_marker) begin
            push_word[TsW-1:0]      = ts_q;
            push_word[AER_WIDTH-2]  = 1'b1;
        end else begin
            push_word[AdrW-1:0] = base_q + AdrW'(low_idx);
        end

        pend_d     = pend_q;
        base_d     = base_q;
        marker_d   = marker_q;
        ts_d       = ts_q;
        overflow_d = overflow_q;
        if (SPIKE_VALID && ready) begin
            pend_d = SPIKE_VEC;
            base_d = SPIKE_GROUP_ADDR;
        end else if (push_spike) begin
            pend_d = pend_q & (pend_q - POST_NEUR_PARALLEL'(1));
        end
        if (TSTEP_MARK && ready) begin
            marker_d = 1'b1;
            ts_d     = CURRENT_TIME_STEP;
        end else if (push_marker) begin
            marker_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (CLR_OVERFLOW) begin
            overflow_d = 1'b0;
        end
    end

    // Transmit FSM and FIFO pointer bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = mem_q[rd_ptr_q];
                    state_d = StReq;
                end
            end
            StReq:    if (ack_sync_q) state_d = StAckLow;
            StAckLow: if (!ack_sync_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q     <= '0;
            base_q     <= '0;
            marker_q   <= 1'b0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            base_q     <= base_d;
            marker_q   <= marker_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            ack_meta_q <= AEROUT_ACK;
            ack_sync_q <= ack_meta_q;
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign SPIKE_READY = ready;
    assign AEROUT_REQ  = (state_q == StReq);
    assign AEROUT_ADDR = addr_q;
    assign FIFO_COUNT  = count_q;
    assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with a behavioural AER receiver that records
// every handshaken word and watches address stability while REQ is high.
module tb_spike_aer_encoder;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        SPIKE_VALID;
    logic [3:0]  SPIKE_VEC;
    logic [9:0]  SPIKE_GROUP_ADDR;
    logic        TSTEP_MARK;
    logic [2:0]  CURRENT_TIME_STEP;
    logic        CLR_OVERFLOW;
    logic        SPIKE_READY;
    logic        AEROUT_REQ;
    logic [11:0] AEROUT_ADDR;
    logic        AEROUT_ACK;
    logic [4:0]  FIFO_COUNT;
    logic        OVERFLOW;

    always #5 CLK = ~CLK;

    spike_aer_encoder dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .SPIKE_VALID       (SPIKE_VALID),
        .SPIKE_VEC         (SPIKE_VEC),
        .SPIKE_GROUP_ADDR  (SPIKE_GROUP_ADDR),
        .TSTEP_MARK        (TSTEP_MARK),
        .CURRENT_TIME_STEP (CURRENT_TIME_STEP),
        .CLR_OVERFLOW      (CLR_OVERFLOW),
        .SPIKE_READY       (SPIKE_READY),
        .AEROUT_REQ        (AEROUT_REQ),
        .AEROUT_ADDR       (AEROUT_ADDR),
        .AEROUT_ACK        (AEROUT_ACK),
        .FIFO_COUNT        (FIFO_COUNT),
        .OVERFLOW          (OVERFLOW)
    );

    int          ntot = 0;
    int          npass = 0;
    logic [11:0] rx_q[$];
    logic [11:0] exp_q[$];
    bit          ack_hold = 1'b0;
    bit          rand_ack = 1'b0;
    int          ack_delay = 0;
    int          dly_cnt = 0;
    int          unstable = 0;
    logic        req_prev = 1'b0;
    logic [11:0] addr_prev = '0;

    // External receiver: raises ACK after ack_delay cycles of REQ, drops it once REQ falls.
    initial begin
        AEROUT_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (AEROUT_REQ && req_prev && (AEROUT_ADDR !== addr_prev)) unstable++;
            req_prev  = AEROUT_REQ;
            addr_prev = AEROUT_ADDR;
            if (AEROUT_REQ && !AEROUT_ACK && !ack_hold) begin
                if (dly_cnt >= ack_delay) begin
                    rx_q.push_back(AEROUT_ADDR);
                    AEROUT_ACK = 1'b1;
                    dly_cnt    = 0;
                    ack_delay  = rand_ack ? int'($urandom_range(0, 20)) : 0;
                end else begin
                    dly_cnt++;
                end
            end else if (!AEROUT_REQ && AEROUT_ACK) begin
                AEROUT_ACK = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntot++;
        assert (obs === exp_v) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic send(input logic [3:0] vec, input logic [9:0] base, input logic valid,
                        input logic mark, input logic [2:0] ts);
        SPIKE_VALID       = valid;
        SPIKE_VEC         = vec;
        SPIKE_GROUP_ADDR  = base;
        TSTEP_MARK        = mark;
        CURRENT_TIME_STEP = ts;
        tick();
        SPIKE_VALID = 1'b0;
        TSTEP_MARK  = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget, output bit ok);
        for (int i = 0; i < budget && !SPIKE_READY; i++) tick();
        ok = SPIKE_READY;
        if (!ok) chk(tag, SPIKE_READY, 1);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
        if (rx_q.size() < n) chk(tag, rx_q.size(), n);
    endtask

    initial begin
        bit          ok;
        bit          abort;
        logic [3:0]  v;
        logic [9:0]  b;
        logic        m;
        logic [2:0]  t;
        logic [11:0] w;

        RST_N = 1'b0;
        SPIKE_VALID = 1'b0; SPIKE_VEC = '0; SPIKE_GROUP_ADDR = '0;
        TSTEP_MARK = 1'b0; CURRENT_TIME_STEP = '0; CLR_OVERFLOW = 1'b0;
        repeat (3) tick();
        chk("rst_ready", SPIKE_READY, 1);
        chk("rst_req", AEROUT_REQ, 0);
        chk("rst_addr", AEROUT_ADDR, 0);
        chk("rst_count", FIFO_COUNT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Two-bit vector: timing of READY, push, REQ rise, ACK-to-REQ-fall, next word.
        send(4'b1010, 10'h010, 1'b1, 1'b0, 3'd0);
        chk("t1_ready_n0", SPIKE_READY, 0);
        tick();
        chk("t1_ready_n1", SPIKE_READY, 0);
        chk("t1_count_n1", FIFO_COUNT, 1);
        chk("t1_req_n1", AEROUT_REQ, 0);
        tick();
        chk("t1_ready_n2", SPIKE_READY, 1);
        chk("t1_req_n2", AEROUT_REQ, 1);
        chk("t1_addr_n2", AEROUT_ADDR, 12'h011);
        chk("t1_count_n2", FIFO_COUNT, 1);
        tick();
        chk("t1_req_n3", AEROUT_REQ, 1);
        tick();
        chk("t1_req_n4", AEROUT_REQ, 1);
        tick();
        chk("t1_req_fall", AEROUT_REQ, 0);
        repeat (3) tick();
        chk("t1_req_gap", AEROUT_REQ, 0);
        tick();
        chk("t1_req_2nd", AEROUT_REQ, 1);
        chk("t1_addr_2nd", AEROUT_ADDR, 12'h013);
        wait_rx("t1_rx_timeout", 2, 100);
        chk("t1_rx0", rx_q[0], 12'h011);
        chk("t1_rx1", rx_q[1], 12'h013);
        repeat (20) tick();
        rx_q.delete();

        // Spike and marker in the same cycle: spike word first, then marker.
        send(4'b0001, 10'h3FC, 1'b1, 1'b1, 3'd5);
        chk("t2_ready_n0", SPIKE_READY, 0);
        tick();
        chk("t2_ready_n1", SPIKE_READY, 0);
        tick();
        chk("t2_ready_n2", SPIKE_READY, 1);
        chk("t2_count_n2", FIFO_COUNT, 1);
        wait_rx("t2_rx_timeout", 2, 100);
        chk("t2_rx0", rx_q[0], 12'h3FC);
        chk("t2_rx1", rx_q[1], 12'h405);
        repeat (20) tick();
        rx_q.delete();

        // Empty vector is accepted and produces nothing.
        send(4'b0000, 10'h020, 1'b1, 1'b0, 3'd0);
        chk("t2z_ready", SPIKE_READY, 1);
        chk("t2z_count", FIFO_COUNT, 0);
        repeat (10) tick();
        chk("t2z_rx", rx_q.size(), 0);

        // FIFO fill with ACK held off, drops, overflow set/clear priority, then drain.
        ack_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ready("t3_ready_timeout", 50, ok);
            send(4'b1111, 10'h100 + 10'(4 * k), 1'b1, 1'b0, 3'd0);
        end
        repeat (5) tick();
        chk("t3_count_full", FIFO_COUNT, 16);
        chk("t3_ready_stall", SPIKE_READY, 0);
        chk("t3_req_held", AEROUT_REQ, 1);
        chk("t3_addr_head", AEROUT_ADDR, 12'h100);
        send(4'b0011, 10'h200, 1'b1, 1'b0, 3'd0);
        chk("t3_ovf_set", OVERFLOW, 1);
        CLR_OVERFLOW = 1'b1;
        send(4'b0001, 10'h204, 1'b1, 1'b0, 3'd0);
        CLR_OVERFLOW = 1'b0;
        chk("t4_ovf_set_wins", OVERFLOW, 1);
        CLR_OVERFLOW = 1'b1;
        tick();
        CLR_OVERFLOW = 1'b0;
        chk("t4_ovf_clr", OVERFLOW, 0);
        chk("t3_count_after_drop", FIFO_COUNT, 16);
        ack_hold = 1'b0;
        wait_rx("t3_rx_timeout", 20, 1000);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t3_rx%0d", k), rx_q[k], 12'h100 + 12'(k));
        end
        repeat (30) tick();
        chk("t3_rx_len", rx_q.size(), 20);
        chk("t3_count_end", FIFO_COUNT, 0);
        rx_q.delete();

        // Asynchronous reset with REQ high and seven words queued.
        ack_hold = 1'b1;
        wait_ready("t5_ready_timeout", 50, ok);
        send(4'b1111, 10'h200, 1'b1, 1'b0, 3'd0);
        wait_ready("t5_ready_timeout", 50, ok);
        send(4'b1111, 10'h204, 1'b1, 1'b0, 3'd0);
        repeat (6) tick();
        chk("t5_pre_count", FIFO_COUNT, 7);
        chk("t5_pre_req", AEROUT_REQ, 1);
        RST_N = 1'b0;
        #1;
        chk("t5_req_async", AEROUT_REQ, 0);
        chk("t5_count_async", FIFO_COUNT, 0);
        chk("t5_ready_async", SPIKE_READY, 1);
        tick();
        RST_N = 1'b1;
        ack_hold = 1'b0;
        repeat (30) tick();
        chk("t5_no_stale", rx_q.size(), 0);
        chk("t5_count_post", FIFO_COUNT, 0);

        // Random vectors and markers with random ACK delay against a reference expansion.
        rand_ack = 1'b1;
        abort = 1'b0;
        unstable = 0;
        rx_q.delete();
        for (int k = 0; k < 1000 && !abort; k++) begin
            v = 4'($urandom_range(0, 15));
            b = {8'($urandom), 2'b00};
            m = ($urandom_range(0, 7) == 0);
            t = 3'($urandom);
            wait_ready("t6_ready_timeout", 1000, ok);
            if (!ok) abort = 1'b1;
            else begin
                for (int i = 0; i < 4; i++) begin
                    if (v[i]) begin
                        w = {2'b00, b + 10'(i)};
                        exp_q.push_back(w);
                    end
                end
                if (m) begin
                    w = {2'b01, 7'd0, t};
                    exp_q.push_back(w);
                end
                send(v, b, 1'b1, m, t);
            end
        end
        if (!abort) wait_rx("t6_rx_timeout", exp_q.size(), 60000);
        repeat (60) tick();
        chk("t6_len", rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            if (rx_q[k] !== exp_q[k]) begin
                chk($sformatf("t6_word%0d", k), rx_q[k], exp_q[k]);
                break;
            end
        end
        chk("t6_addr_stable", unstable, 0);
        chk("t6_ovf", OVERFLOW, 0);
        chk("t6_count_end", FIFO_COUNT, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
